// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ==========================================================================
// uart_tx_fifo_if : valid/ready byte handshake feeding uart_tx_fifo
// Revision: 1.0
// ==========================================================================
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ==========================================================================
// uart_tx_fifo : UART transmitter fed by a circular FIFO, back-to-back frames
// Revision: 1.0
// ==========================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic                        sys_clk,
  input  wire logic                        sys_rst_n,
  uart_tx_fifo_if.slave                    in_if,
  output logic                             txd,
  output logic                             tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ready, push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head_data;
  logic                 head_parity;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;

  // Ready depends only on registered occupancy, never on tx_valid.
  assign ready          = (level_q != LVL_FULL);
  assign in_if.tx_ready = ready;
  assign push           = in_if.tx_valid && ready;
  assign fifo_empty     = (level_q == '0);
  assign head_data      = mem_q[rd_ptr_q];
  assign head_parity    = (^head_data) ^ (PARITY == 1);
  assign bit_end        = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.tx_data;
  end

  // txd_d is the level the line takes in the cycle after this edge.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    txd_d    = txd_q;
    pop      = 1'b0;
    if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = head_data;
          parity_d = head_parity;
          baud_d   = '0;
          txd_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              txd_d   = parity_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // A queued byte starts its frame with no idle cycle in between.
            if (!fifo_empty) begin
              pop      = 1'b1;
              shift_d  = head_data;
              parity_d = head_parity;
              txd_d    = 1'b0;
              state_d  = S_START;
            end else begin
              txd_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
    end
  end

  assign txd        = txd_q;
  assign tx_busy    = (state_q != S_IDLE) || (level_q != '0);
  assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ==========================================================================
// tb_uart_tx_fifo : four configurations driven side by side; line waveforms
// are compared with frames built from the bit list. Revision: 1.0
// ==========================================================================
module tb_uart_tx_fifo;
  localparam int CPB  = 4;
  localparam int NDUT = 4;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       rst_n_v [NDUT];
  logic [7:0] data_v  [NDUT];
  logic       valid_v [NDUT];
  logic       txd_w   [NDUT];
  logic       busy_w  [NDUT];
  logic       ready_w [NDUT];
  logic [2:0] level_w [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] push_q [$];
  logic       line_q [$];
  int first_level, max_level, ready_rule_bad, saw_not_ready, accepted;
  logic busy_last, busy_after, txd_after;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_e ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_o ();
  uart_tx_fifo_if #(.DATA_BITS(5)) if_5 ();

  assign if_a.tx_data = data_v[0];      assign if_a.tx_valid = valid_v[0]; assign ready_w[0] = if_a.tx_ready;
  assign if_e.tx_data = data_v[1];      assign if_e.tx_valid = valid_v[1]; assign ready_w[1] = if_e.tx_ready;
  assign if_o.tx_data = data_v[2];      assign if_o.tx_valid = valid_v[2]; assign ready_w[2] = if_o.tx_ready;
  assign if_5.tx_data = data_v[3][4:0]; assign if_5.tx_valid = valid_v[3]; assign ready_w[3] = if_5.tx_ready;

  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_a (.sys_clk(sys_clk), .sys_rst_n(rst_n_v[0]), .in_if(if_a), .txd(txd_w[0]), .tx_busy(busy_w[0]), .fifo_level(level_w[0]));
  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_e (.sys_clk(sys_clk), .sys_rst_n(rst_n_v[1]), .in_if(if_e), .txd(txd_w[1]), .tx_busy(busy_w[1]), .fifo_level(level_w[1]));
  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_o (.sys_clk(sys_clk), .sys_rst_n(rst_n_v[2]), .in_if(if_o), .txd(txd_w[2]), .tx_busy(busy_w[2]), .fifo_level(level_w[2]));
  uart_tx_fifo #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_5 (.sys_clk(sys_clk), .sys_rst_n(rst_n_v[3]), .in_if(if_5), .txd(txd_w[3]), .tx_busy(busy_w[3]), .fifo_level(level_w[3]));

  function automatic int dbits_of(input int sel);
    return (sel == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int sel);
    return (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
  endfunction
  function automatic int stop_of(input int sel);
    return (sel == 1 || sel == 2) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int sel);
    return CPB * (1 + dbits_of(sel) + ((par_of(sel) != 0) ? 1 : 0) + stop_of(sel));
  endfunction

  // Frame as a per-cycle line level: start, data LSB first, parity, stop.
  function automatic logic [47:0] frame_wave(input int sel, input logic [7:0] d);
    logic [47:0] w;
    int db, ones, b;
    logic pbit;
    w = '1; db = dbits_of(sel); ones = 0;
    for (int i = 0; i < db; i++) ones += int'(d[i]);
    pbit = (par_of(sel) == 2) ? logic'(ones % 2) : logic'((ones + 1) % 2);
    for (int c = 0; c < frame_len(sel); c++) begin
      b = c / CPB;
      if (b == 0)                                w[c] = 1'b0;
      else if (b <= db)                          w[c] = d[b-1];
      else if (par_of(sel) != 0 && b == db + 1)  w[c] = pbit;
      else                                       w[c] = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [47:0] obs_frame(input int sel, input int idx);
    logic [47:0] w;
    int fl;
    w = '1; fl = frame_len(sel);
    for (int c = 0; c < fl; c++) w[c] = line_q[idx*fl + c];
    return w;
  endfunction

  // Holds tx_valid through push_q while recording the line from the first start-bit cycle.
  task automatic run_burst(input int sel);
    int total;
    total = push_q.size() * frame_len(sel);
    line_q.delete();
    max_level = 0; ready_rule_bad = 0; saw_not_ready = 0; accepted = 0;
    @(negedge sys_clk);
    fork
      begin : drv
        int i, guard;
        logic acc;
        i = 0; guard = 0;
        while (i < push_q.size() && guard < 4000) begin
          data_v[sel]  = push_q[i];
          valid_v[sel] = 1'b1;
          acc = ready_w[sel];
          @(negedge sys_clk);
          if (acc) i++;
          guard++;
        end
        valid_v[sel] = 1'b0;
        accepted = i;
      end
      begin : mon
        @(negedge sys_clk);
        first_level = int'(level_w[sel]);
        for (int c = 0; c < total; c++) begin
          @(negedge sys_clk);
          line_q.push_back(txd_w[sel]);
          if (int'(level_w[sel]) > max_level) max_level = int'(level_w[sel]);
          if (ready_w[sel] !== (level_w[sel] != 3'd4)) ready_rule_bad++;
          if (ready_w[sel] === 1'b0) saw_not_ready = 1;
          busy_last = busy_w[sel];
        end
        @(negedge sys_clk);
        busy_after = busy_w[sel];
        txd_after  = txd_w[sel];
      end
    join
  endtask

  task automatic test_reset();
    for (int s = 0; s < NDUT; s++) rst_n_v[s] = 1'b0;
    repeat (5) @(negedge sys_clk);
    for (int s = 0; s < NDUT; s++) rst_n_v[s] = 1'b1;
    @(negedge sys_clk);
    n_checks++; if (txd_w[0] !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd_w[0]); else n_pass++;
    n_checks++; if (ready_w[0] !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_w[0]); else n_pass++;
    n_checks++; if (busy_w[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_w[0]); else n_pass++;
    n_checks++; if (level_w[0] !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level_w[0]); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [47:0] exp_w, obs_w;
    push_q.delete(); push_q.push_back(8'hA5);
    run_burst(0);
    n_checks++; if (first_level !== 1) $display("FAIL single_level_after_push: got %0d expected 1", first_level); else n_pass++;
    exp_w = frame_wave(0, 8'hA5); obs_w = obs_frame(0, 0);
    n_checks++; if (obs_w !== exp_w) $display("FAIL single_frame: got %h expected %h", obs_w, exp_w); else n_pass++;
    n_checks++; if (busy_last !== 1'b1) $display("FAIL single_busy_in_stop: got %b expected 1", busy_last); else n_pass++;
    n_checks++; if (busy_after !== 1'b0 || txd_after !== 1'b1)
      $display("FAIL single_tail: got busy=%b txd=%b expected busy=0 txd=1", busy_after, txd_after); else n_pass++;
  endtask

  task automatic test_parity();
    logic [47:0] exp_w, obs_w;
    for (int sel = 1; sel <= 2; sel++) begin
      push_q.delete(); push_q.push_back(8'hA5); push_q.push_back(8'($urandom));
      run_burst(sel);
      for (int f = 0; f < push_q.size(); f++) begin
        exp_w = frame_wave(sel, push_q[f]); obs_w = obs_frame(sel, f);
        n_checks++; if (obs_w !== exp_w) $display("FAIL parity_frame sel%0d f%0d: got %h expected %h", sel, f, obs_w, exp_w); else n_pass++;
      end
      n_checks++; if (busy_after !== 1'b0 || txd_after !== 1'b1)
        $display("FAIL parity_tail sel%0d: got busy=%b txd=%b expected busy=0 txd=1", sel, busy_after, txd_after); else n_pass++;
    end
  endtask

  task automatic test_five_bits();
    logic [47:0] exp_w, obs_w;
    push_q.delete(); push_q.push_back(8'h1F); push_q.push_back(8'($urandom)); push_q.push_back(8'($urandom));
    run_burst(3);
    for (int f = 0; f < push_q.size(); f++) begin
      exp_w = frame_wave(3, push_q[f]); obs_w = obs_frame(3, f);
      n_checks++; if (obs_w !== exp_w) $display("FAIL five_bit_frame f%0d: got %h expected %h", f, obs_w, exp_w); else n_pass++;
    end
    n_checks++; if (busy_after !== 1'b0 || txd_after !== 1'b1)
      $display("FAIL five_bit_tail: got busy=%b txd=%b expected busy=0 txd=1", busy_after, txd_after); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [47:0] exp_w, obs_w;
    push_q.delete();
    for (int i = 1; i <= 6; i++) push_q.push_back(8'(i));
    run_burst(0);
    n_checks++; if (accepted !== 6) $display("FAIL b2b_accepted: got %0d expected 6", accepted); else n_pass++;
    for (int f = 0; f < 6; f++) begin
      exp_w = frame_wave(0, push_q[f]); obs_w = obs_frame(0, f);
      n_checks++; if (obs_w !== exp_w) $display("FAIL b2b_frame f%0d: got %h expected %h", f, obs_w, exp_w); else n_pass++;
    end
    n_checks++; if (max_level > 4) $display("FAIL b2b_max_level: got %0d expected <=4", max_level); else n_pass++;
    n_checks++; if (saw_not_ready !== 1) $display("FAIL b2b_ready_low: got %0d expected 1", saw_not_ready); else n_pass++;
    n_checks++; if (ready_rule_bad !== 0) $display("FAIL b2b_ready_vs_level: got %0d bad cycles expected 0", ready_rule_bad); else n_pass++;
    n_checks++; if (busy_after !== 1'b0 || txd_after !== 1'b1)
      $display("FAIL b2b_tail: got busy=%b txd=%b expected busy=0 txd=1", busy_after, txd_after); else n_pass++;
  endtask

  task automatic test_random();
    logic [47:0] exp_w, obs_w;
    int sel, n;
    for (int r = 0; r < 6; r++) begin
      sel = int'($urandom_range(0, 3));
      n   = int'($urandom_range(1, 5));
      push_q.delete();
      for (int i = 0; i < n; i++) push_q.push_back(8'($urandom));
      run_burst(sel);
      for (int f = 0; f < n; f++) begin
        exp_w = frame_wave(sel, push_q[f]); obs_w = obs_frame(sel, f);
        n_checks++; if (obs_w !== exp_w) $display("FAIL random_frame r%0d sel%0d f%0d: got %h expected %h", r, sel, f, obs_w, exp_w); else n_pass++;
      end
      n_checks++; if (accepted !== n || max_level > 4)
        $display("FAIL random_fifo r%0d: got accepted=%0d max=%0d expected %0d and <=4", r, accepted, max_level, n); else n_pass++;
      repeat ($urandom_range(0, 6)) @(negedge sys_clk);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b0;
    logic [47:0] exp_w, obs_w;
    int bad;
    b0 = 8'($urandom) & 8'hFB;
    @(negedge sys_clk); data_v[0] = b0;            valid_v[0] = 1'b1;
    @(negedge sys_clk); data_v[0] = 8'($urandom);
    @(negedge sys_clk); data_v[0] = 8'($urandom);
    @(negedge sys_clk); valid_v[0] = 1'b0;
    repeat (12) @(negedge sys_clk);
    n_checks++; if (txd_w[0] !== 1'b0) $display("FAIL midrst_bit2_low: got %b expected 0", txd_w[0]); else n_pass++;
    n_checks++; if (level_w[0] !== 3'd2) $display("FAIL midrst_queued: got %0d expected 2", level_w[0]); else n_pass++;
    #1 rst_n_v[0] = 1'b0;
    #1;
    n_checks++; if (txd_w[0] !== 1'b1) $display("FAIL midrst_txd_async: got %b expected 1", txd_w[0]); else n_pass++;
    n_checks++; if (level_w[0] !== 3'd0 || busy_w[0] !== 1'b0)
      $display("FAIL midrst_flush: got level=%0d busy=%b expected 0 0", level_w[0], busy_w[0]); else n_pass++;
    repeat (3) @(negedge sys_clk);
    rst_n_v[0] = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge sys_clk);
      if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL midrst_idle_after: got %0d active cycles expected 0", bad); else n_pass++;
    push_q.delete(); push_q.push_back(8'h3C);
    run_burst(0);
    exp_w = frame_wave(0, 8'h3C); obs_w = obs_frame(0, 0);
    n_checks++; if (obs_w !== exp_w) $display("FAIL midrst_recover_frame: got %h expected %h", obs_w, exp_w); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < NDUT; s++) begin
      rst_n_v[s] = 1'b0; valid_v[s] = 1'b0; data_v[s] = 8'h00;
    end
    test_reset();
    test_single_frame();
    test_parity();
    test_five_bits();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and valid/ready input handshake. It sends asynchronous serial frames with configurable baud divisor, data width, parity mode and stop-bit count. Queued bytes go back-to-back with no idle gap. It sits between the result/logging path of the MNIST accelerator and the board UART pin, so producers can burst bytes without tracking per-byte busy state.

## Interface
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- BAUD, 115200: line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2).
- DATA_BITS, 8: data bits per frame, legal 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries, power of two, >= 2.
- sys_clk  input  1  clock; all logic rising-edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  byte to queue.
- tx_valid  input  1  tx_data valid this cycle.
- tx_ready  output  1  FIFO can accept; transfer occurs when tx_valid && tx_ready at a rising edge.
- txd  output  1  serial line, idle high, registered.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: txd=1, tx_ready=1, tx_busy=0, fifo_level=0; FIFO pointers cleared, FSM in IDLE, counters 0.
- FIFO: circular buffer with read/write pointers and occupancy counter. tx_ready = (fifo_level != FIFO_DEPTH); no combinational path from tx_valid to tx_ready.
- Push and pop in the same cycle leave fifo_level unchanged; pointers wrap at FIFO_DEPTH.
- Push while full is impossible (tx_ready=0); tx_valid is ignored then and the data is not stored.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: txd=1. If FIFO non-empty: pop into the shift register, compute parity, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, DATA_BITS bits, each CLKS_PER_BIT cycles.
  - PARITY (skipped if PARITY=0): even mode = XOR of data bits; odd mode = its inverse.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle cycle); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary. Bit counter counts 0..DATA_BITS-1.
- Shift-register data is captured at pop; later FIFO writes never alter a frame in flight.
- tx_busy = (state != IDLE) || (fifo_level != 0).
- Reset asserted mid-frame: txd returns to 1 immediately (asynchronously), the FIFO is flushed, and the partial frame is abandoned.

## Timing
- FIFO empty and IDLE, handshake accepted at edge k: fifo_level=1 after edge k; pop at edge k+1; txd=0 after edge k+1 (start-bit latency 1 cycle after acceptance).
- Frame length in cycles = CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS). Every bit lasts exactly CLKS_PER_BIT cycles; no bit may be shortened or stretched.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- tx_ready deasserts at the edge where fifo_level reaches FIFO_DEPTH and reasserts the cycle after the next pop.
- txd changes only at bit boundaries; it is glitch-free from a flop.

## Test plan
- Reset check (CLK_FREQ=400, BAUD=100 so CLKS_PER_BIT=4; 8N1): hold sys_rst_n low 5 cycles, then release -> txd=1, tx_ready=1, tx_busy=0, fifo_level=0.
- Single frame, same config, push 8'hA5 -> after 1 cycle txd is 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles (40 cycles total); tx_busy drops the cycle after the stop bit ends.
- Parity and stop bits: PARITY=2, STOP_BITS=2, push 8'hA5 -> parity bit 0 and 8 stop cycles; PARITY=1 -> parity bit 1; total 48 cycles.
- Burst/full: FIFO_DEPTH=4, hold tx_valid with 8'h01..8'h06 -> tx_ready low once 4 entries are queued and the line is busy. All six bytes are transmitted in order with zero idle cycles between frames, and fifo_level never exceeds 4.
- DATA_BITS=5, push 5'h1F -> 5 data bits of 1 and no bits beyond the fifth; frame is 7*CLKS_PER_BIT cycles.
- Reset mid-frame: assert sys_rst_n during the 3rd data bit with 2 bytes queued -> txd=1 immediately and fifo_level=0. After release, the line stays idle with no residual frame.
